fetch_queue: RTL
================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameters SHALL be as follows, one per line:
- RESET_PC, default 32'h00000000, fetch address loaded on reset.
- DEPTH, default 4, prefetch queue entries; power of two, minimum 2.
REQ-002 Ports SHALL be as follows, one per line, clock and reset first:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- imem_req  out  1  instruction-memory read request.
- imem_addr  out  32  word-aligned read address.
- imem_ack  in  1  read data valid; may arrive in the same cycle as imem_req.
- imem_data  in  32  instruction word, sampled when imem_ack=1.
- redirect  in  1  branch/jump taken; flush the queue and restart fetch.
- redirect_pc  in  32  new fetch address (Branch_address or Jump_address).
- inst_valid  out  1  queue head holds a valid instruction.
- inst_ready  in  1  consumer (decode/control) accepts the head this cycle.
- inst_out  out  32  head instruction word.
- inst_pc_plus4  out  32  fetch address of the head plus 4.

Function
REQ-003 Internal state SHALL be: fetch PC register, DEPTH-entry FIFO of {instruction, pc_plus4}, pending flag, and discard flag.
REQ-004 imem_req SHALL be 1 when pending=1, or when (FIFO count + pending) < DEPTH and rst=0.
REQ-005 imem_addr SHALL equal the fetch PC and SHALL stay stable while imem_req=1 until imem_ack.
REQ-006 Issuing a request SHALL advance the fetch PC by 4, wrapping 32'hFFFFFFFC -> 32'h00000000.
REQ-007 At most one request SHALL be outstanding; a new request is not issued before imem_ack of the previous one.
REQ-008 On imem_ack with discard=0, the FIFO SHALL push {imem_data, imem_addr+4}; the entry is visible at inst_out the next cycle.
REQ-009 Pop SHALL occur when inst_valid & inst_ready; push and pop in the same cycle SHALL leave the count unchanged.
REQ-010 inst_valid SHALL be 1 iff FIFO count > 0; inst_out and inst_pc_plus4 SHALL be stable while inst_valid=1 and inst_ready=0.
REQ-011 On redirect=1:
- the FIFO SHALL empty at the next edge.
- the fetch PC SHALL load {redirect_pc[31:2], 2'b00}.
- a pop in the same cycle SHALL be ignored.
REQ-012 If a request is pending without ack at redirect, it SHALL complete at its old address with discard=1; its data SHALL be dropped, and the first request to the new PC is issued the cycle after that ack.
REQ-013 An imem_ack arriving in the same cycle as redirect SHALL be dropped.
REQ-014 Best-case latency with same-cycle ack: redirect at cycle N -> imem_addr=new PC at N+1 -> inst_valid at N+2.
REQ-015 The FIFO SHALL never overflow; in the full state, imem_req=0 unless a request is pending.

Reset
REQ-016 With rst=1 at an edge, the following SHALL hold: fetch PC=RESET_PC; FIFO empty; pending=0; discard=0; inst_valid=0; imem_req=0; inst_out=0; inst_pc_plus4=0.
REQ-017 rst SHALL override redirect, imem_ack and inst_ready; reset mid-request SHALL abandon the request, and the first imem_req=1 with imem_addr=RESET_PC occurs in the first cycle after rst falls.

Configuration
REQ-018 Macro FETCH_QUEUE_STALL_CNT_EN SHALL control an optional stall counter.
- Defined: adds output fetch_stall_cnt (out, 32), cleared by rst, incremented (wrapping) each cycle with inst_valid=0 and rst=0.
- Undefined: the port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-019 The bench SHALL cover the following directed scenarios:
- Reset release, same-cycle ack, inst_ready=1 -> addresses 0,4,8... issued one per cycle; inst_pc_plus4 = 4,8,12...; inst_valid from cycle 2 on.
- inst_ready=0 for 10 cycles, ack always 1 -> exactly DEPTH entries pushed, imem_req=0 afterwards, head unchanged; release -> in-order drain with no loss.
- Redirect to 32'h00000043 while FIFO holds 3 entries -> inst_valid=0 next cycle; next imem_addr=32'h00000040; next inst_pc_plus4=32'h00000044.
- Ack delayed 3 cycles with redirect in cycle 1 of the wait -> old address held until ack; data dropped; then imem_addr=redirect_pc.
- Fetch PC at 32'hFFFFFFFC -> next imem_addr=32'h00000000; inst_pc_plus4 of that entry = 32'h00000000.
- rst asserted mid-request with a full FIFO -> all outputs 0 next cycle; restart fetch at RESET_PC; with the macro defined, fetch_stall_cnt=0.

Source files
------------

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: one outstanding imem read, DEPTH-entry FIFO of
// {instruction, pc+4}, redirect flush. Define FETCH_QUEUE_STALL_CNT_EN for fetch_stall_cnt.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_out,
  output logic [31:0] inst_pc_plus4
`ifdef FETCH_QUEUE_STALL_CNT_EN
  ,
  output logic [31:0] fetch_stall_cnt
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [31:0]   fetch_pc;
  logic [31:0]   req_addr;
  logic          pending;
  logic          discard;
  logic [31:0]   inst_mem [DEPTH];
  logic [31:0]   pc4_mem  [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [CW-1:0] count;

  logic        issue;
  logic        push;
  logic        pop;
  logic [31:0] redirect_target;

  // A held request keeps its own address so fetch_pc can move on (or be redirected).
  assign imem_req        = pending | (~rst & (count < FULL));
  assign imem_addr       = pending ? req_addr : fetch_pc;
  assign issue           = imem_req & ~pending;
  assign push            = imem_req & imem_ack & ~discard & ~redirect;
  assign pop             = inst_valid & inst_ready & ~redirect;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

  assign inst_valid    = (count != '0);
  assign inst_out      = inst_valid ? inst_mem[rd_ptr] : '0;
  assign inst_pc_plus4 = inst_valid ? pc4_mem[rd_ptr]  : '0;

  // NOTE: sequential state is updated with non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
      pending  <= 1'b0;
      discard  <= 1'b0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else if (redirect) begin
      fetch_pc <= redirect_target;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      // An unacknowledged request must still finish at its old address; its data is dropped.
      if (imem_req && !imem_ack) begin
        pending  <= 1'b1;
        discard  <= 1'b1;
        req_addr <= imem_addr;
      end else begin
        pending  <= 1'b0;
        discard  <= 1'b0;
      end
    end else begin
      if (issue) fetch_pc <= fetch_pc + 32'd4;
      if (issue && !imem_ack) begin
        pending  <= 1'b1;
        req_addr <= fetch_pc;
      end else if (pending && imem_ack) begin
        pending  <= 1'b0;
        discard  <= 1'b0;
      end
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; count gates inst_valid and the
  // zeroed outputs, so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (push) begin
      inst_mem[wr_ptr] <= imem_data;
      pc4_mem[wr_ptr]  <= imem_addr + 32'd4;
    end
  end

`ifdef FETCH_QUEUE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)              fetch_stall_cnt <= '0;
    else if (!inst_valid) fetch_stall_cnt <= fetch_stall_cnt + 32'd1;
  end
`endif

endmodule
